// File: rtl/loader_pkg.sv
// Shared types and constants for the INSTMEM boot loader.
// State encoding, default memory depth and length-field width.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam int DEPTH_WORDS_DEF = 1024;
    localparam int LEN_W           = 16;
    localparam int BYTE_CNT_W      = 2;

    // States in which the loader drives byte_ready and busy.
    function automatic logic is_loading(input state_e s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs four little-endian stream bytes into one 32-bit word.
// word/word_ready are valid in the cycle the 4th byte is accepted.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [31:0]           shift_q;
    logic [31:0]           shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q;

    // Shift right so the first byte of a word ends up in [7:0].
    assign shift_d    = {byte_in, shift_q[31:8]};
    assign word       = shift_d;
    assign word_ready = byte_en && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_en) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/instmem_loader.sv
// Boot loader: streams a length-prefixed image into INSTMEM and
// holds the core in reset until the whole image is written.
module instmem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int ADDR_W      = 12
) (
    input  logic              CLK100MHZ,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [31:0]       im_wr_data,
    output logic              core_nrst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

    state_e             state_q;
    state_e             state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_in;
    logic [IDX_W-1:0]   word_idx_q;
    logic               byte_ready_q;
    logic               im_wr_en_q;
    logic [ADDR_W-1:0]  im_wr_addr_q;
    logic [31:0]        im_wr_data_q;
    logic               core_nrst_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               accept;
    logic               enter_len0;
    logic               pack_en;
    logic               word_ready;
    logic [31:0]        word;
    logic               last_word;

    assign accept     = byte_valid && byte_ready_q;
    assign len_in     = {byte_data, len_q[7:0]};
    assign pack_en    = accept && (state_q == S_DATA);
    assign last_word  = (LEN_W'(word_idx_q) == len_q - 16'd1);
    assign enter_len0 = start && ((state_q == S_IDLE) ||
                                  (state_q == S_DONE) ||
                                  (state_q == S_ERR));

    byte_packer u_packer (
        .clk        (CLK100MHZ),
        .rst        (rst),
        .clear      (enter_len0),
        .byte_en    (pack_en),
        .byte_in    (byte_data),
        .word_ready (word_ready),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (accept) state_d = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if (len_in == '0)
                        state_d = S_DONE;
                    else if (len_in > DEPTH_L)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (word_ready && last_word) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_ready_q <= 1'b0;
            im_wr_en_q   <= 1'b0;
            im_wr_addr_q <= '0;
            im_wr_data_q <= '0;
            core_nrst_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= is_loading(state_d);
            busy_q       <= is_loading(state_d);
            done_q       <= (state_d == S_DONE);
            err_q        <= (state_d == S_ERR);
            core_nrst_q  <= (state_d == S_DONE);
            im_wr_en_q   <= 1'b0;

            if (state_q == S_LEN0 && accept)
                len_q[7:0] <= byte_data;

            if (state_q == S_LEN1 && accept) begin
                len_q[15:8] <= byte_data;
                word_idx_q  <= '0;
            end

            if (state_q == S_DATA && word_ready) begin
                im_wr_en_q   <= 1'b1;
                im_wr_addr_q <= {word_idx_q[ADDR_W-3:0], 2'b00};
                im_wr_data_q <= word;
                word_idx_q   <= word_idx_q + IDX_W'(1);
            end
        end
    end

    assign byte_ready = byte_ready_q;
    assign im_wr_en   = im_wr_en_q;
    assign im_wr_addr = im_wr_addr_q;
    assign im_wr_data = im_wr_data_q;
    assign core_nrst  = core_nrst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instmem_loader.sv
// Scoreboard bench for instmem_loader: expected writes are queued
// by the stimulus and popped by a negedge monitor.
module tb_instmem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_wr_en;
    logic [11:0] im_wr_addr;
    logic [31:0] im_wr_data;
    logic        core_nrst;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cyc[$];
    int  cyc;
    int  tests;
    int  fails;

    instmem_loader dut (
        .CLK100MHZ  (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .core_nrst  (core_nrst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        wr_t e;
        cyc = cyc + 1;
        if (im_wr_en) begin
            wr_cyc.push_back(cyc);
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_write addr=%h data=%h",
                         im_wr_addr, im_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (im_wr_addr !== e.addr || im_wr_data !== e.data ||
                    done !== e.last || core_nrst !== e.last) begin
                    fails = fails + 1;
                    $display("FAIL write got addr=%h data=%h done=%b nrst=%b exp addr=%h data=%h last=%b",
                             im_wr_addr, im_wr_data, done, core_nrst,
                             e.addr, e.data, e.last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic with_valid);
        start      = 1'b1;
        byte_valid = with_valid;
        byte_data  = 8'h05;
        tick();
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            tick();
            n = n + 1;
        end
        if (n == 50) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL accept_timeout byte=%h", b);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d,
                        input logic l);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] prog[10];

    initial begin
        logic [7:0] b;
        tests      = 0;
        fails      = 0;
        cyc        = 0;
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        prog = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
        tick();
        tick();
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_wr_en", 32'(im_wr_en), 32'd0);
        chk("rst_addr", 32'(im_wr_addr), 32'd0);
        chk("rst_data", im_wr_data, 32'd0);
        chk("rst_nrst", 32'(core_nrst), 32'd0);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
        rst = 1'b0;

        // Back-to-back N=2 load.
        wr_cyc.delete();
        push(12'h000, 32'h00000013, 1'b0);
        push(12'h004, 32'h00100093, 1'b1);
        pulse_start(1'b0);
        chk("len0_busy", 32'(busy), 32'd1);
        chk("len0_ready", 32'(byte_ready), 32'd1);
        for (int i = 0; i < 10; i++) send_byte(prog[i]);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_nrst", 32'(core_nrst), 32'd1);
        chk("b2b_ready", 32'(byte_ready), 32'd0);
        drain("b2b_drain");
        chk("b2b_nwr", 32'(wr_cyc.size()), 32'd2);
        if (wr_cyc.size() == 2)
            chk("b2b_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);

        // Start from DONE with a simultaneous byte; then gappy stream.
        push(12'h000, 32'h00000013, 1'b0);
        push(12'h004, 32'h00100093, 1'b1);
        pulse_start(1'b1);
        chk("restart_nrst", 32'(core_nrst), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            send_byte(prog[i]);
            if (i >= 2 && i < 9)
                chk("gap_ready", 32'(byte_ready), 32'd1);
            tick();
        end
        chk("gap_done", 32'(done), 32'd1);
        drain("gap_drain");

        // Oversize length -> sticky ERR, then recover with N=1.
        pulse_start(1'b0);
        send_byte(8'h01);
        send_byte(8'h04);
        chk("err_set", 32'(err), 32'd1);
        chk("err_ready", 32'(byte_ready), 32'd0);
        chk("err_nrst", 32'(core_nrst), 32'd0);
        byte_valid = 1'b1;
        tick();
        tick();
        byte_valid = 1'b0;
        chk("err_sticky", {30'd0, err, done}, 32'd2);
        push(12'h000, 32'hDEADBEEF, 1'b1);
        pulse_start(1'b0);
        chk("err_exit", 32'(err), 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        chk("n1_done", 32'(done), 32'd1);
        drain("n1_drain");

        // Zero length, then a full-depth image.
        pulse_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_nrst", 32'(core_nrst), 32'd1);
        drain("zero_drain");
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] b0;
            b0 = 8'(4 * i);
            push(12'(4 * i), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0},
                 i == 1023);
        end
        pulse_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h04);
        for (int k = 0; k < 4096; k++) begin
            b = 8'(k);
            send_byte(b);
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_addr", 32'(im_wr_addr), 32'hFFC);
        drain("full_drain");

        // Reset in the middle of the second word.
        wr_cyc.delete();
        push(12'h000, 32'h03020100, 1'b0);
        pulse_start(1'b0);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int k = 0; k < 6; k++) begin
            b = 8'(k);
            send_byte(b);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_nrst", 32'(core_nrst), 32'd0);
        chk("midrst_flags", {29'd0, busy, done, err}, 32'd0);
        for (int k = 0; k < 10; k++) tick();
        chk("midrst_nwr", 32'(wr_cyc.size()), 32'd1);
        chk("midrst_q", 32'(exp_q.size()), 32'd0);

        // start during DATA is ignored; start in DONE re-enters LEN0.
        push(12'h000, 32'h44332211, 1'b1);
        pulse_start(1'b0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start(1'b0);
        chk("data_start_busy", 32'(busy), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("data_start_done", 32'(done), 32'd1);
        drain("data_start_drain");
        pulse_start(1'b0);
        chk("done_start_nrst", 32'(core_nrst), 32'd0);
        chk("done_start_len0", {30'd0, busy, byte_ready}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
